// File: rtl/accel_pkg.sv
// Shared constants and FSM state type for the ADXL345 SPI reader.
package accel_pkg;

  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_DATAX0      = 8'h32;
  localparam logic [7:0] VAL_MEASURE     = 8'h08;
  localparam logic [7:0] VAL_FMT_2G      = 8'h00;
  // Read bit plus multi-byte bit on top of the DATAX0 address.
  localparam logic [7:0] CMD_READ_XY     = 8'hC0 | REG_DATAX0;

  typedef enum logic [2:0] {
    ST_INIT_PWR,
    ST_INIT_FMT,
    ST_IDLE,
    ST_READ,
    ST_UPDATE
  } state_t;

  function automatic logic [7:0] tx_byte_for(input state_t st, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      ST_INIT_PWR: b = (idx == 3'd0) ? REG_POWER_CTL : VAL_MEASURE;
      ST_INIT_FMT: b = (idx == 3'd0) ? REG_DATA_FORMAT : VAL_FMT_2G;
      ST_READ:     b = (idx == 3'd0) ? CMD_READ_XY : 8'h00;
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One full-duplex 8-bit SPI mode-3 transfer: SCLK idles high, MOSI shifts on
// the falling edge, MISO is sampled on the rising edge.
//
// Handshake: start is accepted when idle, or in the final cycle of a byte when
// done is high, which chains bytes with no SCLK gap. done pulses one cycle
// before the final high phase ends; rx_byte is already complete by then.
module spi_byte_xfer #(
  parameter int CLK_DIV = 25
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_sclk,
  output logic       spi_mosi
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_PRE = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_sr;
  logic          last_edge;

  assign last_edge = busy && spi_sclk && (cnt == HALF_END) && (bit_idx == 3'd7);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_sr    <= '0;
      rx_byte  <= '0;
      spi_sclk <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (!busy || last_edge)) begin
        busy     <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= tx_byte[7];
        tx_sr    <= {tx_byte[6:0], 1'b0};
        cnt      <= '0;
        bit_idx  <= '0;
      end else if (busy) begin
        if (cnt != HALF_END) begin
          cnt <= cnt + 1'b1;
          if (spi_sclk && (bit_idx == 3'd7) && (cnt == HALF_PRE)) done <= 1'b1;
        end else begin
          cnt <= '0;
          if (!spi_sclk) begin
            spi_sclk <= 1'b1;
            rx_byte  <= {rx_byte[6:0], spi_miso};
          end else if (bit_idx == 3'd7) begin
            busy <= 1'b0;
          end else begin
            spi_sclk <= 1'b0;
            spi_mosi <= tx_sr[7];
            tx_sr    <= {tx_sr[6:0], 1'b0};
            bit_idx  <= bit_idx + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// Polls an ADXL345 over SPI, extracts 10-bit X/Y and outputs a moving
// average of the last 2^AVG_LOG2 samples per axis with a data_valid strobe.
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AVG_LOG2      = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [9:0] smooth_outx,
  output logic [9:0] smooth_outy,
  output logic       data_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 10 + AVG_LOG2;
  localparam int CW    = $clog2(CLK_DIV);
  localparam int GW    = $clog2(2 * CLK_DIV);
  localparam int PW    = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] SETUP_END  = CW'(CLK_DIV - 2);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PERIOD_END = PW'(SAMPLE_PERIOD - 1);

  state_t              state;
  logic                xact_on, sending, start_q, pending, period_en;
  logic [CW-1:0]       setup_cnt;
  logic [2:0]          byte_idx, tx_sel;
  logic [GW-1:0]       gap_cnt;
  logic [PW-1:0]       period_cnt;
  logic [7:0]          x0, y0, xfer_tx, xfer_rx;
  logic [1:0]          x1, y1;
  logic [9:0]          hist_x [DEPTH];
  logic [9:0]          hist_y [DEPTH];
  logic [9:0]          raw_x, raw_y;
  logic [SW-1:0]       sum_x, sum_y, new_sum_x, new_sum_y;
  logic [AVG_LOG2-1:0] ptr;
  logic                xfer_start, xfer_busy, xfer_done, last_byte, tick;

  function automatic logic [SW-1:0] sext(input logic [9:0] v);
    return {{AVG_LOG2{v[9]}}, v};
  endfunction

  assign tick       = period_en && (period_cnt == PERIOD_END);
  assign last_byte  = (state == ST_READ) ? (byte_idx == 3'd4) : (byte_idx == 3'd1);
  // Next byte is launched combinationally off done so SCLK runs without gaps.
  assign xfer_start = start_q | (xfer_done & ~last_byte);
  assign tx_sel     = xfer_done ? byte_idx + 3'd1 : byte_idx;
  assign xfer_tx    = tx_byte_for(state, tx_sel);
  assign raw_x      = {x1, x0};
  assign raw_y      = {y1, y0};
  assign new_sum_x  = sum_x - sext(hist_x[ptr]) + sext(raw_x);
  assign new_sum_y  = sum_y - sext(hist_y[ptr]) + sext(raw_y);

  spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (xfer_start),
    .tx_byte (xfer_tx),
    .spi_miso(spi_miso),
    .busy    (xfer_busy),
    .done    (xfer_done),
    .rx_byte (xfer_rx),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT_PWR;
      spi_cs_n    <= 1'b1;
      xact_on     <= 1'b0;
      sending     <= 1'b0;
      start_q     <= 1'b0;
      pending     <= 1'b0;
      period_en   <= 1'b0;
      setup_cnt   <= '0;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      period_cnt  <= '0;
      x0          <= '0;
      x1          <= '0;
      y0          <= '0;
      y1          <= '0;
      sum_x       <= '0;
      sum_y       <= '0;
      ptr         <= '0;
      smooth_outx <= '0;
      smooth_outy <= '0;
      data_valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
      end
    end else begin
      start_q    <= 1'b0;
      data_valid <= 1'b0;
      if (period_en) period_cnt <= tick ? '0 : period_cnt + 1'b1;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (tick && !(state == ST_IDLE && gap_cnt == '0)) pending <= 1'b1;

      // CS setup: first SCLK fall lands CLK_DIV clocks after CS falls.
      if (xact_on && !sending) begin
        if (setup_cnt == SETUP_END) begin
          start_q <= 1'b1;
          sending <= 1'b1;
        end else begin
          setup_cnt <= setup_cnt + 1'b1;
        end
      end

      if (xfer_done) begin
        byte_idx <= byte_idx + 3'd1;
        if (state == ST_READ) begin
          case (byte_idx)
            3'd1:    x0 <= xfer_rx;
            3'd2:    x1 <= xfer_rx[1:0];
            3'd3:    y0 <= xfer_rx;
            3'd4:    y1 <= xfer_rx[1:0];
            default: ;
          endcase
        end
        if (last_byte) begin
          spi_cs_n <= 1'b1;
          xact_on  <= 1'b0;
          sending  <= 1'b0;
          gap_cnt  <= GAP_LOAD;
          case (state)
            ST_INIT_PWR: state <= ST_INIT_FMT;
            ST_INIT_FMT: begin
              state      <= ST_IDLE;
              period_en  <= 1'b1;
              period_cnt <= '0;
            end
            ST_READ:     state <= ST_UPDATE;
            default:     ;
          endcase
        end
      end

      case (state)
        ST_INIT_PWR, ST_INIT_FMT: begin
          if (!xact_on && !xfer_busy && gap_cnt == '0) begin
            spi_cs_n  <= 1'b0;
            xact_on   <= 1'b1;
            setup_cnt <= '0;
            byte_idx  <= '0;
          end
        end
        ST_IDLE: begin
          if ((tick || pending) && gap_cnt == '0) begin
            state     <= ST_READ;
            pending   <= 1'b0;
            spi_cs_n  <= 1'b0;
            xact_on   <= 1'b1;
            setup_cnt <= '0;
            byte_idx  <= '0;
          end
        end
        ST_UPDATE: begin
          hist_x[ptr] <= raw_x;
          hist_y[ptr] <= raw_y;
          sum_x       <= new_sum_x;
          sum_y       <= new_sum_y;
          // Dropping the low AVG_LOG2 bits is the floor arithmetic shift.
          smooth_outx <= new_sum_x[SW-1:AVG_LOG2];
          smooth_outy <= new_sum_y[SW-1:AVG_LOG2];
          ptr         <= ptr + 1'b1;
          data_valid  <= 1'b1;
          state       <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Directed bench for accel_spi_reader with a behavioural ADXL345 SPI slave.
module tb_accel_spi_reader;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 400;
  localparam int AVG_LOG2      = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso = 1'b0;
  logic [9:0] smooth_outx, smooth_outy;
  logic       data_valid;

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  accel_spi_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .AVG_LOG2     (AVG_LOG2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .smooth_outx(smooth_outx),
    .smooth_outy(smooth_outy),
    .data_valid (data_valid)
  );

  // ---------------- ADXL345 model ----------------
  logic [9:0]  mx = '0, my = '0;
  int          m_rises = 0;
  logic [7:0]  m_cur = '0, m_b0 = '0, m_b1 = '0, rb;
  logic        m_cs_prev = 1'b1, m_sclk_prev = 1'b1;
  logic [23:0] txn_log[$];

  function automatic logic [7:0] resp_byte(input int b);
    case (b)
      1:       return mx[7:0];
      2:       return {{6{mx[9]}}, mx[9:8]};
      3:       return my[7:0];
      4:       return {{6{my[9]}}, my[9:8]};
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clock) begin
    if (!m_cs_prev && spi_cs_n) begin
      txn_log.push_back({8'(m_rises), m_b0, m_b1});
    end else if (!spi_cs_n) begin
      if (m_cs_prev) begin
        m_rises = 0;
        m_cur   = '0;
        m_b0    = '0;
        m_b1    = '0;
      end else if (m_sclk_prev && !spi_sclk) begin
        rb       = resp_byte(m_rises / 8);
        spi_miso = rb[7 - (m_rises % 8)];
      end else if (!m_sclk_prev && spi_sclk) begin
        m_cur = {m_cur[6:0], spi_mosi};
        m_rises++;
        if (m_rises == 8)  m_b0 = m_cur;
        if (m_rises == 16) m_b1 = m_cur;
      end
    end
    m_cs_prev   = spi_cs_n;
    m_sclk_prev = spi_sclk;
  end

  // ---------------- framing monitor ----------------
  int   cyc = 0, cs_fall_c = 0, prev_cs_fall_c = 0, cs_rise_c = 0;
  int   first_fall_c = 0, last_rise_c = 0, last_edge_c = 0, dv_c = 0;
  int   half_min = 9999, half_max = 0, min_gap = 9999;
  logic have_edge = 1'b0, want_first = 1'b0, t_cs_prev = 1'b1, t_sclk_prev = 1'b1;

  always @(negedge clock) begin
    cyc++;
    if (data_valid) dv_c = cyc;
    if (t_cs_prev && !spi_cs_n) begin
      if (cs_rise_c > 0 && (cyc - cs_rise_c) < min_gap) min_gap = cyc - cs_rise_c;
      prev_cs_fall_c = cs_fall_c;
      cs_fall_c      = cyc;
      have_edge      = 1'b0;
      want_first     = 1'b1;
      half_min       = 9999;
      half_max       = 0;
    end else if (!t_cs_prev && spi_cs_n) begin
      cs_rise_c = cyc;
    end else if (!spi_cs_n && (t_sclk_prev != spi_sclk)) begin
      if (have_edge) begin
        if (cyc - last_edge_c < half_min) half_min = cyc - last_edge_c;
        if (cyc - last_edge_c > half_max) half_max = cyc - last_edge_c;
      end
      have_edge   = 1'b1;
      last_edge_c = cyc;
      if (!spi_sclk && want_first) begin
        first_fall_c = cyc;
        want_first   = 1'b0;
      end
      if (spi_sclk) last_rise_c = cyc;
    end
    t_cs_prev   = spi_cs_n;
    t_sclk_prev = spi_sclk;
  end

  // ---------------- checker / driver tasks ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic run_frame(input int vx, input int vy, input logic chk, input int ex, input int ey);
    logic        seen;
    logic [19:0] e;
    seen = 1'b0;
    mx   = vx[9:0];
    my   = vy[9:0];
    if (chk) exp_q.push_back({ex[9:0], ey[9:0]});
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      if (data_valid) seen = 1'b1;
    end
    #1;
    check_eq("data_valid_seen", 32'(seen), 32'd1);
    if (seen && chk) begin
      e = exp_q.pop_front();
      check_eq("smooth_outx", 32'(smooth_outx), 32'(e[19:10]));
      check_eq("smooth_outy", 32'(smooth_outy), 32'(e[9:0]));
    end
  endtask

  task automatic check_init_log;
    check_eq("txn_count", 32'(txn_log.size()), 32'd3);
    if (txn_log.size() >= 3) begin
      check_eq("txn_power_ctl", 32'(txn_log[0]), 32'h102D08);
      check_eq("txn_data_fmt",  32'(txn_log[1]), 32'h103100);
      check_eq("txn_read_cmd",  32'(txn_log[2]), 32'h28F200);
    end
  endtask

  int ramp_x[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
  int ramp_y[8] = '{-13, -25, -38, -50, -63, -75, -88, -100};
  int step_x[8] = '{-19, -38, -57, -75, -94, -113, -132, -150};

  // ---------------- main sequence ----------------
  initial begin
    logic hit;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_cs_n",  32'(spi_cs_n),    32'd1);
    check_eq("rst_sclk",  32'(spi_sclk),    32'd1);
    check_eq("rst_mosi",  32'(spi_mosi),    32'd0);
    check_eq("rst_outx",  32'(smooth_outx), 32'd0);
    check_eq("rst_outy",  32'(smooth_outy), 32'd0);
    check_eq("rst_valid", 32'(data_valid),  32'd0);
    reset_n = 1'b1;

    // X=+100, Y=-100 ramp up over 8 frames
    for (int k = 0; k < 8; k++) begin
      run_frame(100, -100, 1'b1, ramp_x[k], ramp_y[k]);
      if (k == 0) begin
        check_init_log();
        @(negedge clock);
        check_eq("valid_one_cycle", 32'(data_valid), 32'd0);
      end
      if (k == 1) begin
        check_eq("cs_setup",     32'(first_fall_c - cs_fall_c),   32'(CLK_DIV));
        check_eq("cs_hold",      32'(cs_rise_c - last_rise_c),    32'(CLK_DIV));
        check_eq("valid_lat",    32'(dv_c - cs_rise_c),           32'd1);
        check_eq("half_min",     32'(half_min),                   32'(CLK_DIV));
        check_eq("half_max",     32'(half_max),                   32'(CLK_DIV));
        check_eq("frame_period", 32'(cs_fall_c - prev_cs_fall_c), 32'(SAMPLE_PERIOD));
        check_eq("read_sclks",   32'(txn_log[txn_log.size() - 1]), 32'h28F200);
      end
    end

    // flush to zero, then step X to -150
    for (int k = 0; k < 8; k++) run_frame(0, 0, (k == 7), 0, 0);
    for (int k = 0; k < 8; k++) run_frame(-150, 0, 1'b1, step_x[k], 0);

    // full-scale extremes
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      run_frame(-512, 511, 1'b1, -196, 63);
      else if (k == 7) run_frame(-512, 511, 1'b1, -512, 511);
      else             run_frame(-512, 511, 1'b0, 0, 0);
    end

    // reset in the middle of the third byte of a read
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clock);
      if (!spi_cs_n && m_rises >= 20 && m_rises < 24) hit = 1'b1;
    end
    check_eq("midread_reached", 32'(hit), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_cs_n",  32'(spi_cs_n),    32'd1);
    check_eq("async_sclk",  32'(spi_sclk),    32'd1);
    check_eq("async_outx",  32'(smooth_outx), 32'd0);
    check_eq("async_outy",  32'(smooth_outy), 32'd0);
    check_eq("async_valid", 32'(data_valid),  32'd0);
    repeat (10) @(negedge clock);
    txn_log.delete();
    reset_n = 1'b1;
    run_frame(40, -8, 1'b1, 5, -1);
    check_init_log();
    check_eq("cs_gap_min_ok", 32'(min_gap >= 2 * CLK_DIV), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
